// File: rtl/router_seq_top.sv
// Sequential activation router: SRAM-backed tile reader feeding a 3x3 window gatherer and 9-entry MISO.
// Optional window bounds checking is enabled with the ROUTER_BOUNDS_CHECK_EN macro.
module router_seq_top #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_LENGTH = 9,
    parameter int ELEM_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_reg_clear,
    input  logic                  i_sram_write_en,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    input  logic [ADDR_WIDTH-1:0] i_write_addr,
    input  logic                  i_tile_read_en,
    input  logic [ADDR_WIDTH-1:0] i_start_addr,
    input  logic [ADDR_WIDTH-1:0] i_addr_end,
    input  logic                  i_ag_en,
    input  logic                  i_ac_en,
    input  logic                  i_miso_pop_en,
    input  logic [ADDR_WIDTH-1:0] i_o_x,
    input  logic [ADDR_WIDTH-1:0] i_o_y,
    input  logic [ADDR_WIDTH-1:0] i_i_size,
    input  logic [ADDR_WIDTH-1:0] i_o_size,
    output logic                  o_read_done,
    output logic                  o_rr_en,
    output logic [ELEM_WIDTH-1:0] o_miso_data,
    output logic                  o_miso_valid,
    output logic                  o_ag_err
);
    localparam int LANE_BITS = $clog2(DATA_WIDTH / ELEM_WIDTH);
    localparam int TW        = ADDR_WIDTH + LANE_BITS;
    localparam int PW        = $clog2(DATA_LENGTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_data, bus_data;
    logic [ADDR_WIDTH-1:0] ptr, rd_tag, bus_addr;
    logic [1:0]            state;
    logic                  rd_vld, rd_last, rd_issue, clr;

    logic [TW-1:0]         target [DATA_LENGTH];
    logic [DATA_LENGTH-1:0] hit;
    logic [ELEM_WIDTH-1:0] slot [DATA_LENGTH];
    logic [PW-1:0]         pop_ptr;
    logic                  full, ag_bad;

    assign clr      = i_rst | i_reg_clear;
    assign rd_issue = i_en & ~clr & (state == S_READ);

    // NOTE: the memory array has no reset; only control state is cleared, so SRAM contents survive i_rst and i_reg_clear.
    always_ff @(posedge i_clk) begin
        if (i_sram_write_en)
            mem[i_write_addr] <= i_data_in;
    end

    // Non-blocking read returns the pre-write word on a same-address collision.
    always_ff @(posedge i_clk) begin
        if (rd_issue)
            rd_data <= mem[ptr];
        if (i_en)
            bus_data <= rd_data;
    end

    always_ff @(posedge i_clk) begin
        if (clr) begin
            state       <= S_IDLE;
            ptr         <= '0;
            rd_vld      <= 1'b0;
            rd_last     <= 1'b0;
            rd_tag      <= '0;
            o_rr_en     <= 1'b0;
            bus_addr    <= '0;
            o_read_done <= 1'b0;
        end else if (i_en) begin
            rd_vld   <= (state == S_READ);
            rd_last  <= (state == S_READ) && (ptr >= i_addr_end);
            rd_tag   <= ptr;
            o_rr_en  <= rd_vld;
            bus_addr <= rd_tag;
            case (state)
                S_IDLE: if (i_tile_read_en) begin
                    ptr   <= i_start_addr;
                    state <= S_READ;
                end
                S_READ: begin
                    ptr <= ptr + 1'b1;
                    if (ptr >= i_addr_end)
                        state <= S_DONE;
                end
                S_DONE: if (!i_tile_read_en && o_read_done)
                    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            // Leaving DONE waits for the last word to reach the bus, so done cannot stick in IDLE.
            if (state == S_DONE && !i_tile_read_en && o_read_done)
                o_read_done <= 1'b0;
            else if (rd_last)
                o_read_done <= 1'b1;
        end
    end

`ifdef ROUTER_BOUNDS_CHECK_EN
    assign ag_bad = (i_o_x >= i_o_size) || (i_o_y >= i_o_size) ||
                    ((ADDR_WIDTH+1)'(i_o_x) + (ADDR_WIDTH+1)'(2) >= (ADDR_WIDTH+1)'(i_i_size)) ||
                    ((ADDR_WIDTH+1)'(i_o_y) + (ADDR_WIDTH+1)'(2) >= (ADDR_WIDTH+1)'(i_i_size));

    always_ff @(posedge i_clk) begin
        if (clr)
            o_ag_err <= 1'b0;
        else if (i_en && i_ag_en && ag_bad)
            o_ag_err <= 1'b1;
    end
`else
    assign ag_bad   = 1'b0;
    assign o_ag_err = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (clr) begin
            for (int k = 0; k < DATA_LENGTH; k++)
                target[k] <= '0;
        end else if (i_en && i_ag_en && !ag_bad) begin
            for (int ky = 0; ky < 3; ky++)
                for (int kx = 0; kx < 3; kx++)
                    target[ky*3 + kx] <= (TW'(i_o_y) + TW'(ky)) * TW'(i_i_size) + TW'(i_o_x) + TW'(kx);
        end
    end

    assign full         = &hit;
    assign o_miso_valid = full && (pop_ptr < PW'(DATA_LENGTH));

    always_ff @(posedge i_clk) begin
        if (clr) begin
            hit     <= '0;
            pop_ptr <= '0;
            for (int k = 0; k < DATA_LENGTH; k++)
                slot[k] <= '0;
        end else if (i_en) begin
            if (i_ac_en && o_rr_en && !full) begin
                for (int k = 0; k < DATA_LENGTH; k++) begin
                    if (!hit[k] && target[k][TW-1:LANE_BITS] == bus_addr) begin
                        slot[k] <= bus_data[ELEM_WIDTH*int'(target[k][LANE_BITS-1:0]) +: ELEM_WIDTH];
                        hit[k]  <= 1'b1;
                    end
                end
            end
            if (i_miso_pop_en && o_miso_valid) begin
                if (pop_ptr == PW'(DATA_LENGTH - 1)) begin
                    pop_ptr <= '0;
                    hit     <= '0;
                end else begin
                    pop_ptr <= pop_ptr + 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_miso_data = '0;
        if (o_miso_valid)
            o_miso_data = slot[pop_ptr];
    end
endmodule

// File: tb/tb_router_seq_top.sv
// Self-checking bench for router_seq_top: directed cases plus randomized windows against a byte-level model.
// Build with ROUTER_BOUNDS_CHECK_EN defined to exercise the bounds-error expectations.
module tb_router_seq_top;
    localparam int DW = 64;
    localparam int AW = 8;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          rst, en, reg_clear, sram_write_en, tile_read_en, ag_en, ac_en, miso_pop_en;
    logic [DW-1:0] data_in;
    logic [AW-1:0] write_addr, start_addr, addr_end, o_x, o_y, i_size, o_size;
    logic          read_done, rr_en, miso_valid, ag_err;
    logic [EW-1:0] miso_data;

    router_seq_top dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_reg_clear(reg_clear),
        .i_sram_write_en(sram_write_en), .i_data_in(data_in), .i_write_addr(write_addr),
        .i_tile_read_en(tile_read_en), .i_start_addr(start_addr), .i_addr_end(addr_end),
        .i_ag_en(ag_en), .i_ac_en(ac_en), .i_miso_pop_en(miso_pop_en),
        .i_o_x(o_x), .i_o_y(o_y), .i_i_size(i_size), .i_o_size(o_size),
        .o_read_done(read_done), .o_rr_en(rr_en), .o_miso_data(miso_data),
        .o_miso_valid(miso_valid), .o_ag_err(ag_err)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] model_mem [2048];
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int tgt(input int x, input int y, input int isz, input int k);
        return ((y + k / 3) * isz + x + k % 3) % 2048;
    endfunction

    function automatic bit word_read(input int w, input int s, input int e);
        return (s > e) ? (w == s) : (w >= s && w <= e);
    endfunction

    task automatic write_word(input int a, input logic [DW-1:0] d);
        sram_write_en = 1'b1;
        write_addr    = AW'(a);
        data_in       = d;
        tick();
        sram_write_en = 1'b0;
        for (int j = 0; j < 8; j++)
            model_mem[a*8 + j] = d[j*8 +: 8];
    endtask

    task automatic clear_pulse();
        reg_clear = 1'b1;
        tick();
        reg_clear = 1'b0;
    endtask

    task automatic set_window(input int x, input int y, input int isz, input int osz);
        o_x = AW'(x); o_y = AW'(y); i_size = AW'(isz); o_size = AW'(osz);
        ag_en = 1'b1;
        tick();
        ag_en = 1'b0;
    endtask

    task automatic build_expect(input int x, input int y, input int isz);
        exp_q.delete();
        for (int k = 0; k < 9; k++)
            exp_q.push_back(model_mem[tgt(x, y, isz, k)]);
    endtask

    // Streams words s..e; reports how many distinct words reached the bus and the edge on which done rose.
    task automatic run_read(input string tag, input int s, input int e, input int ac_delay, input bit stall,
                            output int words_seen, output int edges_to_done);
        start_addr    = AW'(s);
        addr_end      = AW'(e);
        tile_read_en  = 1'b1;
        ac_en         = (ac_delay == 0);
        words_seen    = 0;
        edges_to_done = -1;
        for (int c = 1; c <= 2000; c++) begin
            logic en_used;
            en_used = en;
            tick();
            if (c == ac_delay) ac_en = 1'b1;
            if (en_used && rr_en) words_seen++;
            if (read_done) begin
                edges_to_done = c;
                break;
            end
            en = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        en = 1'b1;
        check({tag, "_done_seen"}, edges_to_done > 0, 1);
        tile_read_en = 1'b0;
        tick();
        check({tag, "_done_cleared"}, read_done, 0);
        tick();
    endtask

    task automatic pop_all(input string tag);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("%s_valid%0d", tag, i), miso_valid, 1);
            check($sformatf("%s_data%0d", tag, i), miso_data, exp_q[i]);
            miso_pop_en = 1'b1;
            tick();
            miso_pop_en = 1'b0;
        end
        check({tag, "_empty"}, miso_valid, 0);
    endtask

    initial begin
        int words, edges;
        rst = 1'b1; en = 1'b1; reg_clear = 1'b0; sram_write_en = 1'b0; tile_read_en = 1'b0;
        ag_en = 1'b0; ac_en = 1'b0; miso_pop_en = 1'b0; data_in = '0; write_addr = '0;
        start_addr = '0; addr_end = '0; o_x = '0; o_y = '0; i_size = '0; o_size = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_rr_en", rr_en, 0);
        check("rst_done", read_done, 0);
        check("rst_valid", miso_valid, 0);
        check("rst_data", miso_data, 0);
        check("rst_ag_err", ag_err, 0);

        for (int w = 0; w < 4; w++) begin
            logic [DW-1:0] d;
            for (int j = 0; j < 8; j++) d[j*8 +: 8] = 8'(w*8 + j);
            write_word(w, d);
        end

        // Window (0,0) on a 5-wide map.
        set_window(0, 0, 5, 3);
        run_read("t1", 0, 3, 1, 1'b0, words, edges);
        check("t1_words", words, 4);
        check("t1_done_edge", edges, 6);
        build_expect(0, 0, 5);
        pop_all("t1");

        // Window (2,2): bottom-right pixel of a 3x3 output.
        set_window(2, 2, 5, 3);
        run_read("t2", 0, 3, 0, 1'b0, words, edges);
        build_expect(2, 2, 5);
        pop_all("t2");

        // Out-of-bounds window: with checking, targets keep the (2,2) window.
        set_window(3, 0, 5, 3);
`ifdef ROUTER_BOUNDS_CHECK_EN
        check("bounds_err", ag_err, 1);
        build_expect(2, 2, 5);
`else
        check("bounds_err", ag_err, 0);
        build_expect(3, 0, 5);
`endif
        run_read("tb", 0, 3, 0, 1'b0, words, edges);
        pop_all("tb");
        clear_pulse();
        check("bounds_err_cleared", ag_err, 0);

        // Single word read: targets 8..12 never arrive.
        set_window(0, 0, 5, 3);
        run_read("t3", 0, 0, 0, 1'b0, words, edges);
        check("t3_words", words, 1);
        check("t3_done_edge", edges, 3);
        check("t3_never_valid", miso_valid, 0);

        // Reset on the second READ cycle.
        clear_pulse();
        set_window(0, 0, 5, 3);
        start_addr = 8'd0; addr_end = 8'd3; tile_read_en = 1'b1; ac_en = 1'b1;
        tick(); tick();
        rst = 1'b1; tile_read_en = 1'b0;
        tick();
        rst = 1'b0;
        check("rstmid_rr_en", rr_en, 0);
        check("rstmid_done", read_done, 0);
        check("rstmid_valid", miso_valid, 0);
        for (int i = 0; i < 5; i++) tick();
        check("rstmid_rr_quiet", rr_en, 0);
        check("rstmid_no_capture", miso_valid, 0);

        // Pop while empty is ignored; reg_clear mid-pop keeps SRAM.
        miso_pop_en = 1'b1;
        tick();
        miso_pop_en = 1'b0;
        check("pop_empty_valid", miso_valid, 0);
        set_window(0, 0, 5, 3);
        run_read("t5", 0, 3, 0, 1'b0, words, edges);
        build_expect(0, 0, 5);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_pre_data%0d", i), miso_data, exp_q[i]);
            miso_pop_en = 1'b1;
            tick();
            miso_pop_en = 1'b0;
        end
        clear_pulse();
        check("t5_clear_valid", miso_valid, 0);
        set_window(0, 0, 5, 3);
        run_read("t5r", 0, 3, 0, 1'b0, words, edges);
        pop_all("t5r");

        // Randomized memory (written with i_en randomly low) and windows.
        for (int a = 0; a < 256; a++) begin
            en = $urandom_range(0, 1) != 0;
            write_word(a, {$urandom, $urandom});
        end
        en = 1'b1;
        for (int t = 0; t < 16; t++) begin
            int isz, osz, x, y, minw, maxw, s, e, nexp;
            bit all_in;
            isz = $urandom_range(3, 40);
            osz = isz - 2;
            x = $urandom_range(0, osz - 1);
            y = $urandom_range(0, osz - 1);
            minw = tgt(x, y, isz, 0) / 8;
            maxw = tgt(x, y, isz, 8) / 8;
            case ($urandom_range(0, 3))
                0, 1: begin
                    s = (minw > 2) ? minw - $urandom_range(0, 2) : 0;
                    e = maxw + $urandom_range(0, 2);
                    if (e > 255) e = 255;
                end
                2: begin
                    s = minw + $urandom_range(0, 1);
                    e = maxw;
                end
                default: begin
                    s = minw;
                    e = (minw > 0) ? minw - 1 : 0;
                end
            endcase
            en = 1'b0;
            write_word(tgt(x, y, isz, $urandom_range(0, 8)) / 8, {$urandom, $urandom});
            en = 1'b1;
            clear_pulse();
            set_window(x, y, isz, osz);
            run_read($sformatf("r%0d", t), s, e, 0, 1'b1, words, edges);
            nexp = (s > e) ? 1 : e - s + 1;
            check($sformatf("r%0d_words", t), words, nexp);
            all_in = 1'b1;
            for (int k = 0; k < 9; k++)
                if (!word_read(tgt(x, y, isz, k) / 8, s, e)) all_in = 1'b0;
            build_expect(x, y, isz);
            if (all_in)
                pop_all($sformatf("r%0d", t));
            else
                check($sformatf("r%0d_partial", t), miso_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
